// File: rtl/stream_mux8_rr_if.sv
// rtl/stream_mux8_rr_if.sv - eight-producer to one-consumer stream bundle; STREAM_MUX8_PKT_EN adds last flags
interface stream_mux8_rr_if #(
  parameter int WIDTH = 8
);
  logic [7:0]         in_valid;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_ready;
`ifdef STREAM_MUX8_PKT_EN
  logic [7:0]         in_last;
  logic               out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
`endif
endinterface

// File: rtl/stream_mux8_rr.sv
// rtl/stream_mux8_rr.sv - eight-channel round-robin stream mux with registered, source-tagged output
// STREAM_MUX8_PKT_EN: lock the grant to one channel until its in_last beat
module stream_mux8_rr #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  stream_mux8_rr_if.slave bus
);
  logic [2:0]       ptr;
  logic [2:0]       ptr_nxt;
  logic [2:0]       rr_grant;
  logic             rr_found;
  logic [2:0]       grant;
  logic             grant_ok;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;
  logic [2:0]       idx;

  // First valid channel at or after ptr, wrapping modulo 8.
  always_comb begin
    rr_grant = ptr;
    rr_found = 1'b0;
    idx      = ptr;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + k[2:0];
      if (!rr_found && bus.in_valid[idx]) begin
        rr_found = 1'b1;
        rr_grant = idx;
      end
    end
  end

`ifdef STREAM_MUX8_PKT_EN
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] lock_ch;
  logic [2:0] lock_ch_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lock_ch <= 3'd0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
    end
  end

  // Inside a packet only the locked channel may move; ptr waits for the last beat.
  always_comb begin
    grant       = rr_grant;
    grant_ok    = rr_found;
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    ptr_nxt     = ptr;
    if (state == LOCKED) begin
      grant    = lock_ch;
      grant_ok = bus.in_valid[lock_ch];
    end
    if (xfer) begin
      if (bus.in_last[grant]) begin
        state_nxt = IDLE;
        ptr_nxt   = grant + 3'd1;
      end else begin
        state_nxt   = LOCKED;
        lock_ch_nxt = grant;
      end
    end
  end
`else
  assign grant    = rr_grant;
  assign grant_ok = rr_found;
  assign ptr_nxt  = xfer ? grant + 3'd1 : ptr;
`endif

  assign load_en     = !bus.out_valid || bus.out_ready;
  assign xfer        = grant_ok && load_en && !rst;
  assign bus.in_ready = xfer ? (8'd1 << grant) : 8'd0;
  assign grant_data  = bus.in_data[grant*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= 3'd0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= 3'd0;
`ifdef STREAM_MUX8_PKT_EN
      bus.out_last  <= 1'b0;
`endif
    end else begin
      ptr <= ptr_nxt;
      if (xfer) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= grant_data;
        bus.out_sel   <= grant;
`ifdef STREAM_MUX8_PKT_EN
        bus.out_last  <= bus.in_last[grant];
`endif
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux8_rr.sv
// tb/tb_stream_mux8_rr.sv - directed bench for stream_mux8_rr
module tb_stream_mux8_rr;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stream_mux8_rr_if #(.WIDTH(8)) bus ();

  stream_mux8_rr #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [7:0] val);
    bus.in_data[ch*8 +: 8] = val;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 8'hFF;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
`ifdef STREAM_MUX8_PKT_EN
    bus.in_last   = 8'h00;
`endif
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 8'h00);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_out_sel", bus.out_sel, 3'd0);
    bus.in_valid = 8'h00;
    rst = 1'b0;
    tick();

    // single channel 5
    set_data(5, 8'hA5);
    bus.in_valid = 8'h20;
    #1;
    check("ch5_in_ready", bus.in_ready, 8'h20);
    tick();
    bus.in_valid = 8'h00;
    check("ch5_out_valid", bus.out_valid, 1'b1);
    check("ch5_out_data", bus.out_data, 8'hA5);
    check("ch5_out_sel", bus.out_sel, 3'd5);
    tick();
    check("drain_out_valid", bus.out_valid, 1'b0);
    check("drain_data_hold", bus.out_data, 8'hA5);

    // fairness from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) set_data(c, 8'(c));
    bus.in_valid = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("rr_sel_%0d", i), bus.out_sel, 32'(i % 8));
      check($sformatf("rr_data_%0d", i), bus.out_data, 32'(i % 8));
      check($sformatf("rr_valid_%0d", i), bus.out_valid, 1'b1);
    end
    bus.in_valid = 8'h00;
    tick();

    // backpressure with channels 2 and 6
    set_data(2, 8'h22);
    set_data(6, 8'h66);
    bus.in_valid = 8'h44;
    tick();
    check("bp_first_sel", bus.out_sel, 3'd2);
    bus.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_in_ready_%0d", i), bus.in_ready, 8'h00);
      tick();
      check($sformatf("bp_sel_%0d", i), bus.out_sel, 3'd2);
      check($sformatf("bp_valid_%0d", i), bus.out_valid, 1'b1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 8'h40);
    tick();
    check("bp_release_sel", bus.out_sel, 3'd6);
    check("bp_release_data", bus.out_data, 8'h66);

    // pointer wrap through channel 7
    set_data(7, 8'h77);
    set_data(0, 8'h0F);
    bus.in_valid = 8'h80;
    #1;
    check("wrap_ready7", bus.in_ready, 8'h80);
    tick();
    check("wrap_sel7", bus.out_sel, 3'd7);
    bus.in_valid = 8'h81;
    #1;
    check("wrap_ready0", bus.in_ready, 8'h01);
    tick();
    check("wrap_sel0", bus.out_sel, 3'd0);
    check("wrap_data0", bus.out_data, 8'h0F);

    // reset while holding a channel-3 beat
    set_data(3, 8'h33);
    bus.in_valid = 8'h08;
    tick();
    check("mid_sel3", bus.out_sel, 3'd3);
    check("mid_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 8'h00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", bus.out_valid, 1'b0);
    check("mid_rst_sel", bus.out_sel, 3'd0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 8'h09;
    #1;
    check("mid_after_ready", bus.in_ready, 8'h01);
    tick();
    check("mid_after_sel", bus.out_sel, 3'd0);
    bus.in_valid = 8'h00;
    tick();

`ifdef STREAM_MUX8_PKT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_data(2, 8'h20);
    for (int b = 0; b < 3; b++) begin
      set_data(1, 8'(8'h10 + b));
      bus.in_last  = (b == 2) ? 8'h02 : 8'h00;
      bus.in_valid = 8'h06;
      #1;
      check($sformatf("pkt_ready_%0d", b), bus.in_ready, 8'h02);
      tick();
      check($sformatf("pkt_sel_%0d", b), bus.out_sel, 3'd1);
      check($sformatf("pkt_data_%0d", b), bus.out_data, 32'(8'h10 + b));
      check($sformatf("pkt_last_%0d", b), bus.out_last, (b == 2) ? 1'b1 : 1'b0);
    end
    bus.in_last  = 8'h04;
    bus.in_valid = 8'h04;
    tick();
    check("pkt_next_sel", bus.out_sel, 3'd2);
    check("pkt_next_data", bus.out_data, 8'h20);
    bus.in_valid = 8'h00;
    bus.in_last  = 8'h00;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_mux8_rr.md
# stream_mux8_rr

Eight-channel round-robin stream multiplexer: the merge-side counterpart of the team's 1-to-8 demultiplexer. Eight valid/ready input channels are arbitrated onto one registered output stream, tagged with the 3-bit index of the source channel, so a downstream demux can route beats back out. The block sits between eight producers and a single shared consumer.

## Interface
- WIDTH, 8: data width per channel.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; **synchronous, active-high**.
- in_valid  in  8  per-channel valid, bit i = channel i.
- in_data  in  8*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  8  per-channel ready; at most one bit high per cycle.
- out_valid  out  1  output beat present.
- out_data  out  WIDTH  output beat data.
- out_sel  out  3  source channel of the current output beat.
- out_ready  in  1  consumer accepts the beat.
- in_last  in  8  present only with STREAM_MUX8_PKT_EN; end-of-packet flag per channel.
- out_last  out  1  present only with STREAM_MUX8_PKT_EN; registered copy of the granted in_last.

## Operation
- Output register (out_valid, out_data, out_sel) is a one-entry stage.
- load_en = !out_valid || out_ready.
- Round-robin pointer ptr (3 bits): grant = first channel with in_valid set, searching ptr, ptr+1, …, ptr+7, mod 8.
- in_ready[grant] = load_en && any in_valid; all other in_ready bits 0.
- Transfer on channel g when in_valid[g] && in_ready[g]: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= g+1 mod 8 (7 wraps to 0).
- No transfer and out_ready && out_valid: out_valid <= 0; out_data/out_sel hold last value.
- out_valid high and out_ready low: output frozen, all in_ready 0, ptr unchanged.
- No channel valid: ptr unchanged, nothing loaded.
- in_ready may depend combinationally on in_valid and out_ready; out_* outputs are registered only.
- Data width arithmetic: none; data passes unmodified.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, out_last=0, ptr=0, lock state IDLE; in_ready=0 while rst high.
- Latency: input handshake in cycle N -> out_valid/out_data on cycle N+1.
- Throughput: one beat per cycle when out_ready held high.
- Fairness: with all eight channels continuously valid, grant order is 0,1,…,7,0,… (each channel exactly once per 8 accepted beats).
- Simultaneous accept and load in the same cycle: new beat replaces old; out_valid stays 1.
- Reset mid-transfer: any beat in the output register is discarded; ptr returns to 0; next cycle after rst low behaves as from power-up.

## Configuration
- STREAM_MUX8_PKT_EN defined: adds in_last/out_last and a two-state FSM, IDLE and LOCKED. IDLE: arbitrate as above; transfer with in_last[g]=0 -> LOCKED on g. LOCKED: grant forced to locked channel (other channels ignored even if valid); transfer with in_last=1 -> IDLE, ptr <= g+1. ptr does not advance inside a packet. out_last registered with the beat.
- Not defined: per-beat round-robin only; no last ports, no FSM.

## Test plan
- Only channel 5 valid, data 0xA5, out_ready=1 -> in_ready=0x20, next cycle out_valid=1, out_data=0xA5, out_sel=5.
- All eight valid, data=channel index, out_ready=1 for 16 cycles -> out_sel sequence 0..7,0..7, one beat per cycle.
- Channels 2 and 6 valid, out_ready=0 for 4 cycles after first load -> out_sel=2 held, in_ready=0x00 throughout; on release next beat from channel 6.
- ptr=7 wrap: grant channel 7, then channels 0 and 7 valid -> next grant channel 0.
- rst asserted one cycle while out_valid=1 with beat from channel 3 -> next cycle out_valid=0, out_sel=0; then channels 0 and 3 valid -> channel 0 granted first.
- With STREAM_MUX8_PKT_EN: channel 1 sends 3-beat packet (last on beat 3) while channel 2 valid -> beats from channel 1 contiguous, out_last=1 on third, then channel 2 granted.
